// File: rtl/real_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : real_adder_arbiter
// Description : Round-robin arbiter that lets NUM_REQ requesters share one
//               external combinational double-precision adder (BBFAdd). The
//               granted requester's operands are steered to add_in1/add_in2,
//               and the returned sum is captured in a single-entry result
//               register with a valid/ready handshake.
// Ports       : clock, reset           - clock / async active-high reset
//               req_valid/req_ready    - per-requester request handshake
//               req_a, req_b           - packed 64-bit operands per requester
//               add_in1/add_in2/add_out- shared adder connection
//               rsp_valid/rsp_ready    - result handshake
//               rsp_data, rsp_id       - registered sum and its owner
//               issue_cnt              - wrapping count of accepted requests
// Revision    : 1.0 - initial release
// ============================================================================
module real_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    output logic [63:0]             add_in1,
    output logic [63:0]             add_in2,
    input  logic [63:0]             add_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [63:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             issue_cnt
);

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int CAND_W = ID_W + 1;

    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [63:0]       rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic [15:0]       issue_cnt_q, issue_cnt_d;

    logic              slot_free;
    logic              found;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_idx;
    logic [CAND_W-1:0] cand;

    // The slot can take a new result if it is empty or being drained now.
    // Reset gates the grant so no handshake completes while held in reset.
    assign slot_free   = !rsp_valid_q || rsp_ready;
    assign grant_valid = found && slot_free && !reset;

    // Round-robin search: first valid index at or above rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CAND_W'(i);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    // Grant decode and operand steering; everything is zero without a grant.
    always_comb begin
        req_ready = '0;
        add_in1   = '0;
        add_in2   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                add_in1      = req_a[64*i +: 64];
                add_in2      = req_b[64*i +: 64];
            end
        end
    end

    // Next-state: a grant overwrites the slot (covers the drain-and-refill
    // case with no bubble); a drain without a grant only clears valid.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        issue_cnt_d = issue_cnt_q;
        if (grant_valid) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = add_out;
            rsp_id_d    = grant_idx;
            issue_cnt_d = issue_cnt_q + 16'd1;
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign issue_cnt = issue_cnt_q;

endmodule
`default_nettype wire
